// File: rtl/s1_field_arbiter.sv
// Round-robin arbiter that lets NUM_REQ requesters make partial or full updates to one shared {a,b} register.
// Optional S1_ARB_PRIORITY0_EN: requester 0 always wins in IDLE and does not advance the round-robin pointer.
module s1_field_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int A_WIDTH = 4,
  parameter int B_WIDTH = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_REQ-1:0]                   req_valid,
  output logic [NUM_REQ-1:0]                   req_ready,
  input  logic [NUM_REQ*(A_WIDTH+B_WIDTH)-1:0] req_data,
  input  logic [NUM_REQ*2-1:0]                 req_field_en,
  output logic [A_WIDTH-1:0]                   out_a,
  output logic [B_WIDTH-1:0]                   out_b,
  output logic                                 out_valid,
  output logic [$clog2(NUM_REQ)-1:0]           grant_id,
  output logic                                 busy
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int DW  = A_WIDTH + B_WIDTH;

  typedef struct packed {
    logic [A_WIDTH-1:0] a;
    logic [B_WIDTH-1:0] b;
  } field_t;

  typedef enum logic [1:0] {IDLE, ARB_GRANT, COMMIT} state_t;

  state_t             state_q;
  logic [IDW-1:0]     rr_ptr_q;
  logic [IDW-1:0]     grant_id_q;
  logic [NUM_REQ-1:0] req_ready_q;
  logic               busy_q;
  logic               out_valid_q;
  field_t             shared_q;
  field_t             hold_q;
  logic [1:0]         hold_en_q;

  logic               any_valid;
  logic               hi_found;
  logic [IDW-1:0]     hi_idx;
  logic [IDW-1:0]     lo_idx;
  logic [IDW-1:0]     win_idx;
  logic [NUM_REQ-1:0] win_onehot_d;
  logic               sel_valid;
  field_t             sel_data;
  logic [1:0]         sel_en;
  logic [IDW-1:0]     rr_ptr_d;

  // Descending scan: lo_idx ends on the lowest valid index, hi_idx on the lowest one at or above rr_ptr.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    any_valid    = 1'b0;
    hi_found     = 1'b0;
    hi_idx       = '0;
    lo_idx       = '0;
    win_onehot_d = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        any_valid = 1'b1;
        lo_idx    = IDW'(i);
        if (IDW'(i) >= rr_ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = IDW'(i);
        end
      end
    end
    win_idx = hi_found ? hi_idx : lo_idx;
`ifdef S1_ARB_PRIORITY0_EN
    if (req_valid[0]) win_idx = '0;
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      win_onehot_d[i] = (win_idx == IDW'(i));
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    sel_en    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == IDW'(i)) begin
        sel_valid = req_valid[i];
        sel_data  = req_data[i*DW +: DW];
        sel_en    = req_field_en[i*2 +: 2];
      end
    end
    rr_ptr_d = (grant_id_q == IDW'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      req_ready_q <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      shared_q    <= '0;
      hold_q      <= '0;
      hold_en_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
      out_valid_q <= 1'b0;
      req_ready_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (any_valid) begin
            grant_id_q  <= win_idx;
            req_ready_q <= win_onehot_d;
            busy_q      <= 1'b1;
            state_q     <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (sel_valid) begin
            hold_q    <= sel_data;
            hold_en_q <= sel_en;
            state_q   <= COMMIT;
          end else begin
            // Requester withdrew: nothing captured, pointer untouched.
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        COMMIT: begin
          if (hold_en_q[1]) shared_q.a <= hold_q.a;
          if (hold_en_q[0]) shared_q.b <= hold_q.b;
          out_valid_q <= 1'b1;
`ifdef S1_ARB_PRIORITY0_EN
          if (grant_id_q != '0) rr_ptr_q <= rr_ptr_d;
`else
          rr_ptr_q <= rr_ptr_d;
`endif
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign out_a     = shared_q.a;
  assign out_b     = shared_q.b;
  assign out_valid = out_valid_q;
  assign grant_id  = grant_id_q;
  assign busy      = busy_q;

endmodule
